// File: rtl/mem_rd_dec_pkg.sv
// mem_rd_dec_pkg: shared defaults and address-map helpers
// for the RAM / IO read decoder.
package mem_rd_dec_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_RAM_WORDS = 8;
  localparam int DEF_IO_CH     = 2;
  localparam int DEF_IO_BASE   = 65;

  // Which source a read address resolves to
  typedef enum logic [1:0] {
    SEL_ERR,
    SEL_RAM,
    SEL_STAT,
    SEL_IO
  } sel_e;

  // Status word sits just below the first IO channel
  function automatic int io_stat_ad(input int io_base);
    return io_base - 1;
  endfunction

endpackage

// File: rtl/io_chg_det.sv
// io_chg_det: one IO channel sample register plus its
// sticky change flag (set beats read-clear).
module io_chg_det #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prime,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] samp,
  output logic              flag
);

  logic [DATA_W-1:0] samp_q, samp_d;
  logic              flag_q, flag_d;
  logic              chg;

  // New sample every cycle; flag sets on a change once primed
  always_comb begin
    samp_d = din;
    chg    = prime && (din != samp_q);
    flag_d = flag_q;
    if (rd_clr) flag_d = 1'b0;
    if (chg)    flag_d = 1'b1;
  end

  // Sample and flag state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= '0;
      flag_q <= 1'b0;
    end else begin
      samp_q <= samp_d;
      flag_q <= flag_d;
    end
  end

  assign samp = samp_q;
  assign flag = flag_q;

endmodule

// File: rtl/mem_rd_dec.sv
// mem_rd_dec: single-cycle read decoder over a flat RAM,
// sampled IO channels and an IO change-status word.
module mem_rd_dec
  import mem_rd_dec_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAM_WORDS = DEF_RAM_WORDS,
  parameter int IO_CH     = DEF_IO_CH,
  parameter int IO_BASE   = DEF_IO_BASE
) (
  input  logic                        CLK_DC,
  input  logic                        RESET,
  input  logic                        RD_REQ,
  input  logic [ADDR_W-1:0]           RD_AD,
  input  logic [RAM_WORDS*DATA_W-1:0] RAM_FLAT,
  input  logic [IO_CH*DATA_W-1:0]     IO_IN,
  output logic [DATA_W-1:0]           RAM_OUT,
  output logic [ADDR_W-1:0]           RAM_AD_OUT,
  output logic                        RD_ACK,
  output logic                        RD_ERR
);

  localparam int IO_STAT_AD = io_stat_ad(IO_BASE);

  int                ad;
  logic              is_ram, is_stat, is_io;
  sel_e              sel;
  logic [DATA_W-1:0] ram_word, io_word, stat_word;
  logic [DATA_W-1:0] io_samp [IO_CH];
  logic [IO_CH-1:0]  io_flag, io_clr;

  logic [DATA_W-1:0] ram_out_q, ram_out_d;
  logic [ADDR_W-1:0] ram_ad_out_q, ram_ad_out_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rd_err_q, rd_err_d;
  logic              prime_q, prime_d;

  // Per-channel sampler and change flag
  for (genvar g = 0; g < IO_CH; g++) begin : g_ch
    io_chg_det #(
      .DATA_W(DATA_W)
    ) u_det (
      .clk   (CLK_DC),
      .rst   (RESET),
      .prime (prime_q),
      .din   (IO_IN[g*DATA_W +: DATA_W]),
      .rd_clr(io_clr[g]),
      .samp  (io_samp[g]),
      .flag  (io_flag[g])
    );
  end

  // Classify the request address into a source
  always_comb begin
    ad      = int'(RD_AD);
    is_ram  = ad < RAM_WORDS;
    is_stat = ad == IO_STAT_AD;
    is_io   = (ad >= IO_BASE) && (ad < IO_BASE + IO_CH);
    sel     = SEL_ERR;
    unique case (1'b1)
      is_ram:  sel = SEL_RAM;
      is_stat: sel = SEL_STAT;
      is_io:   sel = SEL_IO;
      default: sel = SEL_ERR;
    endcase
  end

  // Candidate read words and per-channel flag clears
  always_comb begin
    ram_word  = '0;
    io_word   = '0;
    stat_word = '0;
    io_clr    = '0;
    for (int k = 0; k < RAM_WORDS; k++) begin
      if (ad == k) ram_word = RAM_FLAT[k*DATA_W +: DATA_W];
    end
    for (int i = 0; i < IO_CH; i++) begin
      stat_word[i] = io_flag[i];
      if (ad == IO_BASE + i) begin
        io_word   = io_samp[i];
        io_clr[i] = RD_REQ;
      end
    end
  end

  // Next output state; unmapped reads keep the old data
  always_comb begin
    ram_out_d    = ram_out_q;
    ram_ad_out_d = ram_ad_out_q;
    rd_ack_d     = RD_REQ;
    rd_err_d     = 1'b0;
    prime_d      = 1'b1;
    if (RD_REQ) begin
      ram_ad_out_d = RD_AD;
      unique case (sel)
        SEL_RAM:  ram_out_d = ram_word;
        SEL_STAT: ram_out_d = stat_word;
        SEL_IO:   ram_out_d = io_word;
        default:  rd_err_d  = 1'b1;
      endcase
    end
  end

  // Output registers and the post-reset prime bit
  always_ff @(posedge CLK_DC or posedge RESET) begin
    if (RESET) begin
      ram_out_q    <= '0;
      ram_ad_out_q <= '0;
      rd_ack_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      prime_q      <= 1'b0;
    end else begin
      ram_out_q    <= ram_out_d;
      ram_ad_out_q <= ram_ad_out_d;
      rd_ack_q     <= rd_ack_d;
      rd_err_q     <= rd_err_d;
      prime_q      <= prime_d;
    end
  end

  assign RAM_OUT    = ram_out_q;
  assign RAM_AD_OUT = ram_ad_out_q;
  assign RD_ACK     = rd_ack_q;
  assign RD_ERR     = rd_err_q;

endmodule

// File: tb/tb_mem_rd_dec.sv
// tb_mem_rd_dec: vector table, randomized model compare
// and a reset-in-flight sequence for mem_rd_dec.
module tb_mem_rd_dec;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int RW = 8;
  localparam int NC = 2;
  localparam int IB = 65;
  localparam int SA = 64;
  localparam int NV = 21;

  typedef struct {
    logic          req;
    logic [AW-1:0] ad;
    logic [DW-1:0] io0;
    logic [DW-1:0] io1;
    logic          ack;
    logic          err;
    logic [DW-1:0] out;
    logic [AW-1:0] oad;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic req;
  logic [AW-1:0] ad;
  logic [DW-1:0] ram_w [RW];
  logic [DW-1:0] io_v [NC];
  logic [RW*DW-1:0] ram_flat;
  logic [NC*DW-1:0] io_in;
  logic [DW-1:0] ram_out;
  logic [AW-1:0] ram_ad_out;
  logic rd_ack;
  logic rd_err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_out;
  logic [AW-1:0] m_ad;
  logic          m_ack;
  logic          m_err;
  logic [DW-1:0] m_samp [NC];
  logic          m_flag [NC];
  logic          m_prime;

  vec_t tbl [NV];

  always #5 clk = ~clk;

  always_comb begin
    ram_flat = '0;
    io_in    = '0;
    for (int k = 0; k < RW; k++) ram_flat[k*DW +: DW] = ram_w[k];
    for (int c = 0; c < NC; c++) io_in[c*DW +: DW] = io_v[c];
  end

  mem_rd_dec #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .RAM_WORDS(RW),
    .IO_CH    (NC),
    .IO_BASE  (IB)
  ) dut (
    .CLK_DC    (clk),
    .RESET     (rst),
    .RD_REQ    (req),
    .RD_AD     (ad),
    .RAM_FLAT  (ram_flat),
    .IO_IN     (io_in),
    .RAM_OUT   (ram_out),
    .RAM_AD_OUT(ram_ad_out),
    .RD_ACK    (rd_ack),
    .RD_ERR    (rd_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out   = '0;
    m_ad    = '0;
    m_ack   = 1'b0;
    m_err   = 1'b0;
    m_prime = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_samp[c] = '0;
      m_flag[c] = 1'b0;
    end
  endtask

  // Memory-map rules applied to the inputs present at an edge
  task automatic model_edge();
    int a;
    logic [DW-1:0] st;
    a = int'(ad);
    st = '0;
    for (int c = 0; c < NC; c++) st[c] = m_flag[c];
    m_ack = req;
    m_err = 1'b0;
    if (req) begin
      m_ad = ad;
      if (a < RW) m_out = ram_w[a];
      else if (a == SA) m_out = st;
      else if (a >= IB && a < IB + NC) m_out = m_samp[a-IB];
      else m_err = 1'b1;
    end
    for (int c = 0; c < NC; c++) begin
      if (m_prime && io_v[c] != m_samp[c]) m_flag[c] = 1'b1;
      else if (req && a == IB + c) m_flag[c] = 1'b0;
      m_samp[c] = io_v[c];
    end
    m_prime = 1'b1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".ack"}, 32'(rd_ack), 32'(m_ack));
    chk({nm, ".err"}, 32'(rd_err), 32'(m_err));
    chk({nm, ".out"}, 32'(ram_out), 32'(m_out));
    chk({nm, ".ad"}, 32'(ram_ad_out), 32'(m_ad));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'd3,  16'h0,  16'h0,  1'b1, 1'b0, 16'hBEEF, 8'd3};
    tbl[1]  = '{1'b1, 8'd0,  16'h0,  16'h0,  1'b1, 1'b0, 16'h1000, 8'd0};
    tbl[2]  = '{1'b1, 8'd1,  16'h0,  16'h0,  1'b1, 1'b0, 16'h1001, 8'd1};
    tbl[3]  = '{1'b1, 8'd2,  16'h0,  16'h0,  1'b1, 1'b0, 16'h1002, 8'd2};
    tbl[4]  = '{1'b0, 8'd2,  16'h0,  16'h0,  1'b0, 1'b0, 16'h1002, 8'd2};
    tbl[5]  = '{1'b1, 8'd5,  16'h0,  16'h0,  1'b1, 1'b0, 16'h1234, 8'd5};
    tbl[6]  = '{1'b1, 8'd20, 16'h0,  16'h0,  1'b1, 1'b1, 16'h1234, 8'd20};
    tbl[7]  = '{1'b0, 8'd0,  16'h0,  16'hA5, 1'b0, 1'b0, 16'h1234, 8'd20};
    tbl[8]  = '{1'b1, 8'd64, 16'h0,  16'hA5, 1'b1, 1'b0, 16'h0002, 8'd64};
    tbl[9]  = '{1'b1, 8'd66, 16'h0,  16'hA5, 1'b1, 1'b0, 16'h00A5, 8'd66};
    tbl[10] = '{1'b1, 8'd64, 16'h0,  16'hA5, 1'b1, 1'b0, 16'h0000, 8'd64};
    tbl[11] = '{1'b1, 8'd65, 16'h33, 16'hA5, 1'b1, 1'b0, 16'h0000, 8'd65};
    tbl[12] = '{1'b1, 8'd64, 16'h33, 16'hA5, 1'b1, 1'b0, 16'h0001, 8'd64};
    tbl[13] = '{1'b1, 8'd65, 16'h33, 16'hA5, 1'b1, 1'b0, 16'h0033, 8'd65};
    tbl[14] = '{1'b1, 8'd64, 16'h33, 16'hA5, 1'b1, 1'b0, 16'h0000, 8'd64};
    tbl[15] = '{1'b1, 8'd7,  16'h33, 16'hA5, 1'b1, 1'b0, 16'h1007, 8'd7};
    tbl[16] = '{1'b1, 8'd8,  16'h33, 16'hA5, 1'b1, 1'b1, 16'h1007, 8'd8};
    tbl[17] = '{1'b1, 8'd63, 16'h33, 16'hA5, 1'b1, 1'b1, 16'h1007, 8'd63};
    tbl[18] = '{1'b1, 8'd67, 16'h33, 16'hA5, 1'b1, 1'b1, 16'h1007, 8'd67};
    tbl[19] = '{1'b1, 8'd255,16'h33, 16'hA5, 1'b1, 1'b1, 16'h1007, 8'd255};
    tbl[20] = '{1'b0, 8'd0,  16'h33, 16'hA5, 1'b0, 1'b0, 16'h1007, 8'd255};

    for (int k = 0; k < RW; k++) ram_w[k] = 16'h1000 + 16'(k);
    ram_w[3] = 16'hBEEF;
    ram_w[5] = 16'h1234;
    io_v[0] = '0;
    io_v[1] = '0;
    req = 1'b0;
    ad  = '0;
    rst = 1'b1;
    model_reset();
    #12;
    chk("rst.ack", 32'(rd_ack), 32'd0);
    chk("rst.err", 32'(rd_err), 32'd0);
    chk("rst.out", 32'(ram_out), 32'd0);
    chk("rst.ad", 32'(ram_ad_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();

    for (int r = 0; r < NV; r++) begin
      req     = tbl[r].req;
      ad      = tbl[r].ad;
      io_v[0] = tbl[r].io0;
      io_v[1] = tbl[r].io1;
      step();
      chk($sformatf("tbl%0d.ack", r), 32'(rd_ack), 32'(tbl[r].ack));
      chk($sformatf("tbl%0d.err", r), 32'(rd_err), 32'(tbl[r].err));
      chk($sformatf("tbl%0d.out", r), 32'(ram_out), 32'(tbl[r].out));
      chk($sformatf("tbl%0d.ad", r), 32'(ram_ad_out), 32'(tbl[r].oad));
    end

    for (int k = 0; k < RW; k++) ram_w[k] = 16'($urandom);
    for (int n = 0; n < 400; n++) begin
      req = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: ad = 8'($urandom_range(0, RW - 1));
        1: ad = 8'(SA);
        2: ad = 8'(IB + $urandom_range(0, NC - 1));
        3: ad = 8'(IB + $urandom_range(0, NC - 1));
        default: ad = 8'($urandom_range(0, 255));
      endcase
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 3) == 0) io_v[c] = 16'($urandom_range(0, 3));
      end
      step();
      chk_model($sformatf("rnd%0d", n));
    end

    io_v[0] = 16'h1111;
    io_v[1] = 16'h2222;
    req = 1'b1;
    ad  = 8'd3;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.ack", 32'(rd_ack), 32'd0);
    chk("midrst.err", 32'(rd_err), 32'd0);
    chk("midrst.out", 32'(ram_out), 32'd0);
    chk("midrst.ad", 32'(ram_ad_out), 32'd0);
    @(posedge clk);
    #1;
    chk("inrst.ack", 32'(rd_ack), 32'd0);
    chk("inrst.out", 32'(ram_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    model_reset();
    step();
    chk("postrst.ack", 32'(rd_ack), 32'd0);
    chk("postrst.out", 32'(ram_out), 32'd0);
    req = 1'b1;
    ad  = 8'(SA);
    step();
    chk("postrst.stat", 32'(ram_out), 32'h0000);
    chk("postrst.stack", 32'(rd_ack), 32'd1);
    chk_model("postrst.m0");
    ad = 8'(IB);
    step();
    chk("postrst.ch0", 32'(ram_out), 32'h1111);
    chk_model("postrst.m1");
    req = 1'b0;
    step();
    chk_model("postrst.m2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
